bus_terminal_fifo: RTL and testbench
====================================

Name: bus_terminal_fifo

Overview:
- Per-terminal interface stage that sits directly on one port of the bus generator/arbiter (bs_gnrtr_n_rbtr); one instance per driver index, drvrs instances total.
- TX side buffers host packets and presents them to the bus as pndng / D_pop, consuming the bus pop strobe.
- RX side accepts bus push / D_push, keeps packets addressed to this terminal or to broadcast, and buffers them for the host.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- deep_fifo, 8, depth of each of the TX and RX FIFOs, in packets; must be ≥2.
- id, 0, 8-bit terminal ID for this port.
- broadcast, 8'hFF, destination ID accepted by every terminal.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- tx_push  in  1  host write strobe.
- tx_data  in  pckg_sz  host packet; sampled when tx_push=1.
- tx_full  out  1  TX FIFO holds deep_fifo packets.
- tx_count  out  $clog2(deep_fifo+1)  TX occupancy.
- tx_drop  out  1  one-cycle pulse: a host push was discarded because TX was full.
- pop  in  1  bus pop strobe from the arbiter.
- pndng  out  1  TX FIFO non-empty.
- D_pop  out  pckg_sz  TX head packet, show-ahead.
- push  in  1  bus delivery strobe from the arbiter.
- D_push  in  pckg_sz  packet delivered by the bus.
- rx_pop  in  1  host read strobe.
- rx_data  out  pckg_sz  RX head packet, show-ahead.
- rx_pndng  out  1  RX FIFO non-empty.
- rx_drop  out  1  one-cycle pulse: an accepted bus packet was discarded because RX was full.
- misaddr_cnt  out  8  count of bus packets rejected by the address filter; saturating.

Behaviour:
- Reset values:
  - All read/write pointers and occupancy counts = 0.
  - pndng=0, rx_pndng=0, tx_full=0, tx_count=0.
  - tx_drop=0, rx_drop=0, misaddr_cnt=0.
  - D_pop=0, rx_data=0.
- Reset asserted mid-operation discards all buffered packets without waiting for a clock edge.
- FIFO storage:
  - Each FIFO is circular over deep_fifo entries.
  - Pointers wrap from deep_fifo-1 to 0.
  - Occupancy is tracked by an explicit counter of width $clog2(deep_fifo+1).
- Show-ahead read:
  - D_pop shows mem[rd_ptr] whenever pndng=1, and is forced to 0 when the FIFO is empty; same rule for rx_data / rx_pndng.
  - A pop at edge N presents the next entry (or 0) after edge N.
- Write latency: a push accepted at edge N sets pndng / rx_pndng and updates tx_count after edge N. The bus may pop that packet at edge N+1 at the earliest.
- Pop on an empty FIFO (pndng=0, or rx_pndng=0 for the RX side) is ignored: no pointer or count change, no error output.
- TX push on full:
  - tx_push=1 with tx_full=1 and pop=0: packet discarded, tx_drop=1 for exactly the following cycle, FIFO unchanged.
  - tx_push=1 with tx_full=1 and pop=1: both happen; the head is removed, the new packet is written, and count stays at deep_fifo.
- Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is stored, so count becomes 1.
- Simultaneous push and pop on a non-empty, non-full FIFO: count is unchanged and both pointers advance.
- RX address filter, with dest = D_push[pckg_sz-1:pckg_sz-8]:
  - When push=1, the packet is accepted only if dest==id or dest==broadcast.
  - A rejected packet is never stored. misaddr_cnt increments by 1 and saturates at 255.
  - An accepted packet follows the same full/empty rules as TX: when RX is full and rx_pop=0, rx_drop pulses for one cycle.
- tx_full and tx_count are registered, consistent with the post-edge FIFO state. No combinational path from tx_push, pop, push or rx_pop to any output.

Test Plan:
- Reset then idle → pndng=0, D_pop=0, rx_pndng=0, rx_data=0, tx_count=0, misaddr_cnt=0.
- Push 16'h0312 at edge N; pop at edge N+1 → pndng=1 and D_pop=16'h0312 after N; pndng=0 and D_pop=0 after N+1.
- deep_fifo=8: push 9 packets 16'h0100..16'h0108 with no pop → tx_full=1, tx_count=8, tx_drop pulses one cycle on the 9th push; then 8 pops return 16'h0100..16'h0107 in order.
- TX full, push 16'hAAAA together with pop → head removed, tx_count stays 8, tx_drop=0, 16'hAAAA is the last packet popped.
- id=3: bus pushes 16'h0311, 16'hFF22, 16'h0533 → rx_data delivers 16'h0311 then 16'hFF22; misaddr_cnt=1.
- Assert reset for half a cycle while tx_count=5 and rx_pndng=1 → all outputs return to reset values before the next edge; a subsequent push of 16'h0777 is popped first.

Source files
------------

// File: rtl/bus_terminal_fifo_if.sv
// Host/bus handshake bundle for one bus terminal.
// Slave side is the terminal; master side is host plus arbiter.
interface bus_terminal_fifo_if #(
  parameter int pckg_sz   = 16,
  parameter int deep_fifo = 8
);
  localparam int CW = $clog2(deep_fifo + 1);

  logic               tx_push;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_full;
  logic [CW-1:0]      tx_count;
  logic               tx_drop;
  logic               pop;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_pop;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_pndng;
  logic               rx_drop;
  logic [7:0]         misaddr_cnt;

  modport slave (
    input  tx_push, tx_data, pop, push, D_push, rx_pop,
    output tx_full, tx_count, tx_drop, pndng, D_pop,
    output rx_data, rx_pndng, rx_drop, misaddr_cnt
  );

  modport master (
    output tx_push, tx_data, pop, push, D_push, rx_pop,
    input  tx_full, tx_count, tx_drop, pndng, D_pop,
    input  rx_data, rx_pndng, rx_drop, misaddr_cnt
  );
endinterface

// File: rtl/bus_terminal_fifo.sv
// Bus terminal: TX FIFO toward the arbiter, address-filtered
// RX FIFO toward the host, both show-ahead circular buffers.
module bus_terminal_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         deep_fifo = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  bus_terminal_fifo_if.slave bus
);
  localparam int PW = $clog2(deep_fifo);
  localparam int CW = $clog2(deep_fifo + 1);
  localparam logic [CW-1:0] FULL = CW'(deep_fifo);
  localparam logic [PW-1:0] LAST = PW'(deep_fifo - 1);

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [pckg_sz-1:0] tx_mem [deep_fifo];
  logic [PW-1:0]      tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic               tx_drop_q, tx_drop_d;
  logic               tx_rd, tx_wr, tx_ne;

  logic [pckg_sz-1:0] rx_mem [deep_fifo];
  logic [PW-1:0]      rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic               rx_drop_q, rx_drop_d;
  logic               rx_rd, rx_wr, rx_ne;

  logic [7:0]         mis_q, mis_d;
  logic [7:0]         dest;
  logic               hit, rx_acc;

  assign dest   = bus.D_push[pckg_sz-1 -: 8];
  assign hit    = (dest == id) || (dest == broadcast);
  assign rx_acc = bus.push && hit;

  // A pop on a full FIFO frees the slot a same-cycle push uses.
  always_comb begin
    tx_rd     = bus.pop && (tx_cnt_q != '0);
    tx_wr     = bus.tx_push && ((tx_cnt_q != FULL) || tx_rd);
    tx_drop_d = bus.tx_push && !tx_wr;
    tx_wp_d   = tx_wr ? nxt(tx_wp_q) : tx_wp_q;
    tx_rp_d   = tx_rd ? nxt(tx_rp_q) : tx_rp_q;
    tx_cnt_d  = tx_cnt_q + CW'(tx_wr) - CW'(tx_rd);

    rx_rd     = bus.rx_pop && (rx_cnt_q != '0);
    rx_wr     = rx_acc && ((rx_cnt_q != FULL) || rx_rd);
    rx_drop_d = rx_acc && !rx_wr;
    rx_wp_d   = rx_wr ? nxt(rx_wp_q) : rx_wp_q;
    rx_rp_d   = rx_rd ? nxt(rx_rp_q) : rx_rp_q;
    rx_cnt_d  = rx_cnt_q + CW'(rx_wr) - CW'(rx_rd);

    mis_d = mis_q;
    if (bus.push && !hit && (mis_q != 8'hFF))
      mis_d = mis_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      tx_drop_q <= 1'b0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      rx_drop_q <= 1'b0;
      mis_q     <= '0;
    end else begin
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_drop_q <= tx_drop_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_drop_q <= rx_drop_d;
      mis_q     <= mis_d;
    end
  end

  // Storage needs no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp_q] <= bus.tx_data;
    if (rx_wr) rx_mem[rx_wp_q] <= bus.D_push;
  end

  assign tx_ne = (tx_cnt_q != '0);
  assign rx_ne = (rx_cnt_q != '0);

  assign bus.pndng       = tx_ne;
  assign bus.D_pop       = tx_ne ? tx_mem[tx_rp_q] : '0;
  assign bus.tx_full     = (tx_cnt_q == FULL);
  assign bus.tx_count    = tx_cnt_q;
  assign bus.tx_drop     = tx_drop_q;
  assign bus.rx_pndng    = rx_ne;
  assign bus.rx_data     = rx_ne ? rx_mem[rx_rp_q] : '0;
  assign bus.rx_drop     = rx_drop_q;
  assign bus.misaddr_cnt = mis_q;
endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed plus random stimulus against a queue-based
// model of the terminal (id=3, depth 8, 16-bit packets).
module tb_bus_terminal_fifo;
  localparam int W = 16;
  localparam int D = 8;

  logic clk;
  logic reset;

  bus_terminal_fifo_if #(.pckg_sz(W), .deep_fifo(D)) bif ();

  bus_terminal_fifo #(
    .pckg_sz(W), .deep_fifo(D),
    .id(8'd3), .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  int           m_mis;
  logic         m_txdrop, m_rxdrop;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pndng",    32'(bif.pndng),    32'(txq.size() > 0));
    chk("D_pop",    32'(bif.D_pop),    txq.size() > 0 ? 32'(txq[0]) : 32'h0);
    chk("tx_count", 32'(bif.tx_count), 32'(txq.size()));
    chk("tx_full",  32'(bif.tx_full),  32'(txq.size() == D));
    chk("tx_drop",  32'(bif.tx_drop),  32'(m_txdrop));
    chk("rx_pndng", 32'(bif.rx_pndng), 32'(rxq.size() > 0));
    chk("rx_data",  32'(bif.rx_data),  rxq.size() > 0 ? 32'(rxq[0]) : 32'h0);
    chk("rx_drop",  32'(bif.rx_drop),  32'(m_rxdrop));
    chk("misaddr",  32'(bif.misaddr_cnt), 32'(m_mis));
  endtask

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_mis    = 0;
    m_txdrop = 1'b0;
    m_rxdrop = 1'b0;
  endtask

  task automatic cycle(input logic tp, input logic [W-1:0] td,
                       input logic p, input logic ps,
                       input logic [W-1:0] dp, input logic rp);
    logic [7:0] dst;
    bif.tx_push = tp;
    bif.tx_data = td;
    bif.pop     = p;
    bif.push    = ps;
    bif.D_push  = dp;
    bif.rx_pop  = rp;
    m_txdrop = 1'b0;
    m_rxdrop = 1'b0;
    if (p && txq.size() > 0) void'(txq.pop_front());
    if (tp) begin
      if (txq.size() < D) txq.push_back(td);
      else m_txdrop = 1'b1;
    end
    if (rp && rxq.size() > 0) void'(rxq.pop_front());
    if (ps) begin
      dst = dp[15:8];
      if (dst == 8'd3 || dst == 8'hFF) begin
        if (rxq.size() < D) rxq.push_back(dp);
        else m_rxdrop = 1'b1;
      end else if (m_mis < 255) begin
        m_mis++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [7:0]   rdst;
    logic [31:0]  rv;
    reset = 1'b1;
    bif.tx_push = 1'b0; bif.tx_data = '0;
    bif.pop = 1'b0; bif.push = 1'b0;
    bif.D_push = '0; bif.rx_pop = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    idle();

    // single packet through TX
    cycle(1'b1, 16'h0312, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // fill past full, then push together with pop
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
    idle();
    cycle(1'b1, 16'hAAAA, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++)
      cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // address filter
    cycle(1'b0, '0, 1'b0, 1'b1, 16'h0311, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'hFF22, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'h0533, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // RX overflow
    for (int i = 0; i < 10; i++)
      cycle(1'b0, '0, 1'b0, 1'b1, 16'h0340 + 16'(i), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'hFF99, 1'b1);

    // mid-operation reset between edges
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
    #4;
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    #2;
    reset = 1'b0;
    cycle(1'b1, 16'h0777, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // misaddress counter saturation
    for (int i = 0; i < 260; i++)
      cycle(1'b0, '0, 1'b0, 1'b1, 16'h5500 + 16'(i), 1'b0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      rv = $urandom;
      rd = rv[15:0];
      case ($urandom_range(0, 2))
        0: rdst = 8'h03;
        1: rdst = 8'hFF;
        default: begin
          rv   = $urandom;
          rdst = rv[7:0];
        end
      endcase
      rv = $urandom;
      cycle(rv[0] | rv[1], rd, rv[2] & rv[3],
            rv[4] | rv[5], {rdst, rv[23:16]}, rv[6] & rv[7]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
